// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like memory port between the inst (IF) and
// data (EX/MEM) requesters. The data requester has priority. A granted request
// is held until the memory accepts it. A source-tag FIFO records who issued each
// accepted transaction, so in-order responses are routed back to that issuer.
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_orphan
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, HOLD_INST, HOLD_DATA} state_e;

    state_e                     state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] tags_q;      // 0 = inst, 1 = data
    logic [PW-1:0]              wptr_q, rptr_q;
    logic [CW-1:0]              cnt_q;
    logic                       orphan_q;

    logic gnt_inst, gnt_data;
    logic full, empty, push, pop, head_tag;

    // Fullness is taken from the registered count, so a pop in this cycle
    // does not free a slot until the next cycle.
    assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);

    // Grant selection and next state. The grant is combinational in IDLE and
    // becomes sticky in HOLD_x until the memory accepts the request.
    always_comb begin
        state_d  = state_q;
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (!full && data_req)      gnt_data = 1'b1;
                    else if (!full && inst_req) gnt_inst = 1'b1;
                    if (gnt_data && !m_addr_ok) state_d = HOLD_DATA;
                    if (gnt_inst && !m_addr_ok) state_d = HOLD_INST;
                end
                HOLD_INST: begin
                    gnt_inst = 1'b1;
                    if (m_addr_ok) state_d = IDLE;
                end
                HOLD_DATA: begin
                    gnt_data = 1'b1;
                    if (m_addr_ok) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m_req   = gnt_inst | gnt_data;
    assign m_wr    = gnt_data ? data_wr    : (gnt_inst ? inst_wr    : 1'b0);
    assign m_size  = gnt_data ? data_size  : (gnt_inst ? inst_size  : 2'b0);
    assign m_addr  = gnt_data ? data_addr  : (gnt_inst ? inst_addr  : 32'b0);
    assign m_wstrb = gnt_data ? data_wstrb : (gnt_inst ? inst_wstrb : 4'b0);
    assign m_wdata = gnt_data ? data_wdata : (gnt_inst ? inst_wdata : 32'b0);

    assign inst_addr_ok = gnt_inst & m_addr_ok;
    assign data_addr_ok = gnt_data & m_addr_ok;

    // Responses are routed by the tag at the head of the FIFO. A response that
    // arrives while the FIFO is empty has no owner and is dropped.
    assign push     = m_req & m_addr_ok;
    assign pop      = m_data_ok & !empty & !reset;
    assign head_tag = tags_q[rptr_q];

    assign inst_data_ok = pop & !head_tag;
    assign data_data_ok = pop &  head_tag;
    assign inst_rdata   = inst_data_ok ? m_rdata : 32'b0;
    assign data_rdata   = data_data_ok ? m_rdata : 32'b0;
    assign err_orphan   = orphan_q;

    // Grant FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Source-tag FIFO. Pointers wrap modulo depth, and push and pop may happen
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tags_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                tags_q[wptr_q] <= gnt_data;
                wptr_q <= (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop)
                rptr_q <= (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky flag for a response that arrives with no outstanding transaction.
    always_ff @(posedge clk) begin
        if (reset)                 orphan_q <= 1'b0;
        else if (m_data_ok && empty) orphan_q <= 1'b1;
    end

endmodule
